cpu_run_control: RTL and testbench

Front-panel run controller that turns raw board inputs into CPU run commands. It debounces the start and step push-buttons, synchronises the step-mode switch, and sequences load → ready → run → halt. It drives the CPU clock-enable and the status levels consumed by the LED status display: start_cpu and step_execution. It sits between the board I/O, the instruction loader (transmit-done) and the CPU core (halt).

---
 rtl/cpu_run_control.sv | 136 +++++++++++++
 tb/tb_cpu_run_control.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_control.sv
// Front-panel run sequencer: synchronises and debounces the panel inputs, then steps
// load -> ready -> run -> halt and gates the CPU clock-enable.
//
// state   | meaning
// S_LOAD  | waiting for the loader to finish filling program memory
// S_READY | program loaded, waiting for a start press
// S_RUN   | CPU enabled (free-run, or one cycle per step press)
// S_HALT  | halt retired; terminal until reset
module cpu_run_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_btn_start,
    input  logic        i_btn_step,
    input  logic        i_sw_step_mode,
    input  logic        i_instr_transmit_done,
    input  logic        i_halt,
    output logic        o_cpu_clk_en,
    output logic        o_start_cpu,
    output logic        o_step_execution,
    output logic [1:0]  o_state,
    output logic [31:0] o_run_cycles
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_READY = 2'd1,
        S_RUN   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // bit 0 = start button, bit 1 = step button, bit 2 = mode switch
    logic [2:0] sync1_q, sync2_q;
    logic [1:0] press;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {i_sw_step_mode, i_btn_step, i_btn_start};
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_db
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 stable_q, stable_d, stable_dly_q, press_q;

        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync2_q[g] != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_d = sync2_q[g];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                cnt_q        <= '0;
                stable_q     <= 1'b0;
                stable_dly_q <= 1'b0;
                press_q      <= 1'b0;
            end else begin
                cnt_q        <= cnt_d;
                stable_q     <= stable_d;
                stable_dly_q <= stable_q;
                press_q      <= stable_q & ~stable_dly_q;
            end
        end

        assign press[g] = press_q;
    end

    state_t      state_q, state_d;
    logic        clk_en_q, clk_en_d;
    logic        start_q, start_d;
    logic        step_mode_q, step_mode_d;
    logic [31:0] run_cycles_q, run_cycles_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_LOAD;
            clk_en_q     <= 1'b0;
            start_q      <= 1'b0;
            step_mode_q  <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            clk_en_q     <= clk_en_d;
            start_q      <= start_d;
            step_mode_q  <= step_mode_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (i_instr_transmit_done) state_d = S_READY;
            S_READY: if (press[0])              state_d = S_RUN;
            S_RUN:   if (i_halt)                state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Halt outranks a coincident step press, so the CPU never advances past a halt.
    always_comb begin
        start_d     = start_q;
        step_mode_d = step_mode_q;
        if (state_q == S_READY && press[0]) begin
            start_d     = 1'b1;
            step_mode_d = sync2_q[2];
        end
        clk_en_d     = (state_q == S_RUN) && !i_halt && (!step_mode_q || press[1]);
        run_cycles_d = run_cycles_q;
        if (clk_en_q && run_cycles_q != 32'hFFFF_FFFF) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    assign o_cpu_clk_en     = clk_en_q;
    assign o_start_cpu      = start_q;
    assign o_step_execution = step_mode_q;
    assign o_state          = state_q;
    assign o_run_cycles     = run_cycles_q;

endmodule

// File: tb/tb_cpu_run_control.sv
// Scenario bench for cpu_run_control with DEBOUNCE_CYCLES = 4: each task schedules stimulus
// by cycle and queues the output vector expected at given cycles, comparing as they come due.
module tb_cpu_run_control;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_btn_start = 1'b0;
    logic        i_btn_step = 1'b0;
    logic        i_sw_step_mode = 1'b0;
    logic        i_instr_transmit_done = 1'b0;
    logic        i_halt = 1'b0;
    logic        o_cpu_clk_en;
    logic        o_start_cpu;
    logic        o_step_execution;
    logic [1:0]  o_state;
    logic [31:0] o_run_cycles;
    logic [36:0] obs;

    typedef struct {
        int          at;
        string       name;
        logic [36:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    cpu_run_control #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(20)) dut (
        .i_clk                 (clk),
        .i_rst                 (i_rst),
        .i_btn_start           (i_btn_start),
        .i_btn_step            (i_btn_step),
        .i_sw_step_mode        (i_sw_step_mode),
        .i_instr_transmit_done (i_instr_transmit_done),
        .i_halt                (i_halt),
        .o_cpu_clk_en          (o_cpu_clk_en),
        .o_start_cpu           (o_start_cpu),
        .o_step_execution      (o_step_execution),
        .o_state               (o_state),
        .o_run_cycles          (o_run_cycles)
    );

    always #5 clk = ~clk;

    assign obs = {o_state, o_cpu_clk_en, o_start_cpu, o_step_execution, o_run_cycles};

    // Vector layout: state, clk_en, start_cpu, step_execution, run_cycles.
    function automatic logic [36:0] pk(logic [1:0] st, logic en, logic sc, logic se,
                                       logic [31:0] rc);
        return {st, en, sc, se, rc};
    endfunction

    function automatic void expect_at(int at, string name, logic [36:0] v);
        exp_t e;
        e.at   = at;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    // Advance past one rising edge; cyc then numbers the edge just taken.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_ready();
        i_rst = 1'b1;
        i_btn_start = 1'b0;
        i_btn_step = 1'b0;
        i_sw_step_mode = 1'b0;
        i_instr_transmit_done = 1'b0;
        i_halt = 1'b0;
        tick();
        i_rst = 1'b0;
        i_instr_transmit_done = 1'b1;
        tick();
        i_instr_transmit_done = 1'b0;
        tick();
    endtask

    // Reset, a start press while loading (ignored), then a one-cycle load-done pulse.
    task automatic test_reset_load();
        int   c0, rel;
        exp_t e;
        c0 = cyc;
        expect_at(c0 + 1,  "reset_values",     pk(2'd0, 0, 0, 0, 0));
        expect_at(c0 + 12, "start_in_load",    pk(2'd0, 0, 0, 0, 0));
        expect_at(c0 + 13, "load_to_ready",    pk(2'd1, 0, 0, 0, 0));
        expect_at(c0 + 16, "ready_holds",      pk(2'd1, 0, 0, 0, 0));
        for (int b = 0; b < 400; b++) begin
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                n_total++;
                if (obs !== e.val) $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, obs, e.val);
                else n_pass++;
            end
            if (exp_q.size() == 0) break;
            rel = cyc - c0;
            i_rst = (rel == 0);
            i_btn_start = (rel >= 1 && rel < 9);
            i_instr_transmit_done = (rel == 12);
            tick();
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL reset_load_timeout: %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Free-run: press at rel 0 reaches S_RUN at edge +8; enable from edge +9; halt sampled at +29.
    task automatic test_free_run();
        int   c0, rel;
        exp_t e;
        go_ready();
        c0 = cyc;
        expect_at(c0 + 7,  "pre_run",     pk(2'd1, 0, 0, 0, 0));
        expect_at(c0 + 8,  "run_entry",   pk(2'd2, 0, 1, 0, 0));
        expect_at(c0 + 9,  "en_first",    pk(2'd2, 1, 1, 0, 0));
        expect_at(c0 + 20, "en_cont",     pk(2'd2, 1, 1, 0, 11));
        expect_at(c0 + 28, "en_pre_halt", pk(2'd2, 1, 1, 0, 19));
        expect_at(c0 + 29, "halt",        pk(2'd3, 0, 1, 0, 20));
        expect_at(c0 + 33, "halt_hold",   pk(2'd3, 0, 1, 0, 20));
        for (int b = 0; b < 400; b++) begin
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                n_total++;
                if (obs !== e.val) $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, obs, e.val);
                else n_pass++;
            end
            if (exp_q.size() == 0) break;
            rel = cyc - c0;
            i_sw_step_mode = 1'b0;
            i_btn_start = (rel < 10);
            i_halt = (rel == 28);
            tick();
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL free_run_timeout: %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Two 3-cycle bounces are rejected; a 6-cycle hold starting rel 15 runs at edge +23.
    task automatic test_debounce();
        int   c0, rel;
        exp_t e;
        go_ready();
        c0 = cyc;
        expect_at(c0 + 14, "glitch_reject", pk(2'd1, 0, 0, 0, 0));
        expect_at(c0 + 22, "db_pre",        pk(2'd1, 0, 0, 0, 0));
        expect_at(c0 + 23, "db_run",        pk(2'd2, 0, 1, 0, 0));
        expect_at(c0 + 24, "db_en",         pk(2'd2, 1, 1, 0, 0));
        for (int b = 0; b < 400; b++) begin
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                n_total++;
                if (obs !== e.val) $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, obs, e.val);
                else n_pass++;
            end
            if (exp_q.size() == 0) break;
            rel = cyc - c0;
            i_btn_start = (rel < 3) || (rel >= 6 && rel < 9) || (rel >= 15 && rel < 21);
            tick();
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL debounce_timeout: %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Step mode: presses at rel 20/40/60 held 8 cycles; each gives one enable at press+8.
    task automatic test_step_mode();
        int   c0, rel, s;
        exp_t e;
        go_ready();
        c0 = cyc;
        expect_at(c0 + 8,  "step_run_entry", pk(2'd2, 0, 1, 1, 0));
        expect_at(c0 + 15, "step_idle",      pk(2'd2, 0, 1, 1, 0));
        for (int k = 0; k < 3; k++) begin
            s = c0 + 20 + 20 * k;
            expect_at(s + 7,  "step_pre",       pk(2'd2, 0, 1, 1, 32'(k)));
            expect_at(s + 8,  "step_en",        pk(2'd2, 1, 1, 1, 32'(k)));
            expect_at(s + 9,  "step_once",      pk(2'd2, 0, 1, 1, 32'(k + 1)));
            expect_at(s + 16, "step_no_repeat", pk(2'd2, 0, 1, 1, 32'(k + 1)));
        end
        expect_at(c0 + 90, "mode_latched", pk(2'd2, 0, 1, 1, 3));
        for (int b = 0; b < 400; b++) begin
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                n_total++;
                if (obs !== e.val) $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, obs, e.val);
                else n_pass++;
            end
            if (exp_q.size() == 0) break;
            rel = cyc - c0;
            i_sw_step_mode = (rel < 75);
            i_btn_start = (rel < 8);
            i_btn_step = (rel >= 20 && rel < 28) || (rel >= 40 && rel < 48) || (rel >= 60 && rel < 68);
            tick();
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL step_mode_timeout: %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Step press taken at edge +28 coincides with halt sampled at +28: halt wins.
    task automatic test_collision();
        int   c0, rel;
        exp_t e;
        go_ready();
        c0 = cyc;
        expect_at(c0 + 27, "collide_pre",   pk(2'd2, 0, 1, 1, 0));
        expect_at(c0 + 28, "collide_halt",  pk(2'd3, 0, 1, 1, 0));
        expect_at(c0 + 29, "collide_no_en", pk(2'd3, 0, 1, 1, 0));
        expect_at(c0 + 62, "halt_terminal", pk(2'd3, 0, 1, 1, 0));
        for (int b = 0; b < 400; b++) begin
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                n_total++;
                if (obs !== e.val) $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, obs, e.val);
                else n_pass++;
            end
            if (exp_q.size() == 0) break;
            rel = cyc - c0;
            i_sw_step_mode = 1'b1;
            i_btn_start = (rel < 8) || (rel >= 40 && rel < 50);
            i_btn_step = (rel >= 20 && rel < 28) || (rel >= 40 && rel < 50);
            i_halt = (rel == 27);
            tick();
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL collision_timeout: %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Reset sampled at edge +16 during free-run; then halt ignored in S_LOAD and S_READY.
    task automatic test_reset_midrun();
        int   c0, rel;
        exp_t e;
        go_ready();
        c0 = cyc;
        expect_at(c0 + 15, "midrun_running", pk(2'd2, 1, 1, 0, 6));
        expect_at(c0 + 16, "midrun_reset",   pk(2'd0, 0, 0, 0, 0));
        expect_at(c0 + 26, "halt_in_load",   pk(2'd0, 0, 0, 0, 0));
        expect_at(c0 + 31, "reload_ready",   pk(2'd1, 0, 0, 0, 0));
        expect_at(c0 + 38, "halt_in_ready",  pk(2'd1, 0, 0, 0, 0));
        for (int b = 0; b < 400; b++) begin
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                n_total++;
                if (obs !== e.val) $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, obs, e.val);
                else n_pass++;
            end
            if (exp_q.size() == 0) break;
            rel = cyc - c0;
            i_sw_step_mode = 1'b0;
            i_btn_start = (rel < 10);
            i_rst = (rel == 15);
            i_halt = (rel >= 20 && rel < 25) || (rel >= 32 && rel < 36);
            i_instr_transmit_done = (rel == 30);
            tick();
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL reset_midrun_timeout: %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset_load();
        test_free_run();
        test_debounce();
        test_step_mode();
        test_collision();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
